// File: rtl/cpu_trace_uart_if.sv
// ---------------------------------------------------------------------------
// cpu_trace_uart_if
//
// Bundles the CPU-side trace inputs and the UART-side outputs of
// cpu_trace_uart. The clock and reset stay as plain ports on the design.
//
// Signals:
//   clk_cpu   prescaled CPU clock (asynchronous to clk, synchronized inside)
//   pc        CPU program counter, 4 bits
//   inst      current instruction word, 8 bits
//   io_out    CPU output port, 4 bits
//   drop_clr  synchronous clear of the sticky drop flag
//   tx        UART serial output, idle high
//   busy      high while a trace line is being transmitted
//   drop      sticky flag: a CPU step arrived while busy
//
// Modports:
//   master  drives the CPU-side signals and observes the UART side
//   slave   the trace port itself
// ---------------------------------------------------------------------------
interface cpu_trace_uart_if;
  logic       clk_cpu;
  logic [3:0] pc;
  logic [7:0] inst;
  logic [3:0] io_out;
  logic       drop_clr;
  logic       tx;
  logic       busy;
  logic       drop;

  modport master (
    output clk_cpu, pc, inst, io_out, drop_clr,
    input  tx, busy, drop
  );

  modport slave (
    input  clk_cpu, pc, inst, io_out, drop_clr,
    output tx, busy, drop
  );
endinterface

// File: rtl/cpu_trace_uart.sv
// ---------------------------------------------------------------------------
// cpu_trace_uart
//
// Serial trace port for the 4-bit CPU board. Each rising edge of the
// prescaled CPU clock triggers one ASCII line describing the CPU state:
//
//   hex(pc) ':' hex(inst[7:4]) hex(inst[3:0]) ' ' hex(io_out) CR LF
//
// The line goes out over a UART, LSB first, one start bit and one stop bit
// per character. Characters follow each other with no idle gap. A step that
// arrives while a line is still being sent is discarded and latches the
// sticky drop flag.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (2..65535, default 434 for
//                 115200 baud from a 50 MHz clock)
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   trc      cpu_trace_uart_if.slave: clk_cpu, pc, inst, io_out, drop_clr
//            in; tx, busy, drop out (all outputs registered)
//
// Build option:
//   TRACE_UART_PARITY_EN  when defined, an even-parity bit (XOR of the data
//                         bits) is sent between data bit 7 and the stop bit
//                         (8E1). When undefined, frames are 8N1.
// ---------------------------------------------------------------------------
module cpu_trace_uart #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic             clk,
  input  logic             reset_n,
  cpu_trace_uart_if.slave  trc
);

`ifdef TRACE_UART_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;
`endif

  // Last value of the bit timer; the timer runs 0..CLKS_PER_BIT-1.
  localparam logic [15:0] TMR_LAST = 16'(CLKS_PER_BIT - 1);

  // ASCII hex digit, uppercase.
  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    logic [7:0] r;
    if (v < 4'd10) begin
      r = 8'h30 + {4'h0, v};
    end else begin
      r = 8'h37 + {4'h0, v};
    end
    return r;
  endfunction

  // Character idx (0..7) of the trace line for snapshot {pc, inst, io_out}.
  function automatic logic [7:0] line_char(input logic [15:0] snap,
                                           input logic [2:0]  idx);
    logic [7:0] r;
    case (idx)
      3'd0:    r = hex_ascii(snap[15:12]);
      3'd1:    r = 8'h3A;
      3'd2:    r = hex_ascii(snap[11:8]);
      3'd3:    r = hex_ascii(snap[7:4]);
      3'd4:    r = 8'h20;
      3'd5:    r = hex_ascii(snap[3:0]);
      3'd6:    r = 8'h0D;
      3'd7:    r = 8'h0A;
      default: r = 8'h0A;
    endcase
    return r;
  endfunction

`ifdef TRACE_UART_PARITY_EN
  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  logic        s1_q, s2_q, s3_q;
  state_e      state_q, state_d;
  logic [15:0] tmr_q, tmr_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  chr_q, chr_d;
  logic [15:0] snap_q, snap_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        drop_q, drop_d;

  logic        step_s;
  logic        tmr_last_s;
  logic        line_done_s;
  logic        accept_s;
  logic [7:0]  chr_byte_s;

  // clk_cpu synchronizer (s1, s2) plus history flop s3 for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= trc.clk_cpu;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Next-state logic: bit timing, character sequencing, capture and drop.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    chr_d   = chr_q;
    snap_d  = snap_q;
    drop_d  = drop_q;
    tx_d    = 1'b1;

    step_s      = s2_q & ~s3_q;
    tmr_last_s  = (tmr_q == TMR_LAST);
    // Final cycle of the LF stop bit: the line ends here, so a step in this
    // same cycle can start the next line without being dropped.
    line_done_s = (state_q == S_STOP) && tmr_last_s && (chr_q == 3'd7);
    accept_s    = step_s && ((state_q == S_IDLE) || line_done_s);

    // Bit timer runs in every non-idle state and restarts per bit.
    if (state_q == S_IDLE) begin
      tmr_d = 16'd0;
    end else if (tmr_last_s) begin
      tmr_d = 16'd0;
    end else begin
      tmr_d = tmr_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_START: begin
        if (tmr_last_s) begin
          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (tmr_last_s) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef TRACE_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef TRACE_UART_PARITY_EN
      S_PARITY: begin
        if (tmr_last_s) begin
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (tmr_last_s) begin
          chr_d = chr_q + 3'd1;
          if (chr_q == 3'd7) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_START;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new line overrides whatever the sequencing above decided.
    if (accept_s) begin
      state_d = S_START;
      tmr_d   = 16'd0;
      bit_d   = 3'd0;
      chr_d   = 3'd0;
      snap_d  = {trc.pc, trc.inst, trc.io_out};
    end else begin
      snap_d  = snap_q;
    end

    // Set wins over clear when both happen in the same cycle.
    if (step_s && !accept_s) begin
      drop_d = 1'b1;
    end else if (trc.drop_clr) begin
      drop_d = 1'b0;
    end else begin
      drop_d = drop_q;
    end

    // Outputs are computed from the next state so tx/busy are registered
    // and line up with the state they describe.
    chr_byte_s = line_char(snap_d, chr_d);
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = chr_byte_s[bit_d];
`ifdef TRACE_UART_PARITY_EN
      S_PARITY: tx_d = even_parity(chr_byte_s);
`endif
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, counters, snapshot and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tmr_q   <= 16'd0;
      bit_q   <= 3'd0;
      chr_q   <= 3'd0;
      snap_q  <= 16'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      chr_q   <= chr_d;
      snap_q  <= snap_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign trc.tx   = tx_q;
  assign trc.busy = busy_q;
  assign trc.drop = drop_q;

endmodule

// File: tb/tb_cpu_trace_uart.sv
// ---------------------------------------------------------------------------
// tb_cpu_trace_uart
//
// Self-checking bench for cpu_trace_uart with CLKS_PER_BIT = 4. A UART
// receiver in the bench decodes tx into bytes (checking bit hold times, the
// stop bit and, in parity builds, the parity bit); lines are compared with
// a model that formats pc/inst/io_out as ASCII directly.
// ---------------------------------------------------------------------------
module tb_cpu_trace_uart;
  localparam int CPB = 4;
`ifdef TRACE_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int LINE_CYC = 8 * FRAME_BITS * CPB;

  logic clk = 1'b0;
  logic reset_n;
  cpu_trace_uart_if trc();

  cpu_trace_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .trc     (trc)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference formatting of one trace line, first character in the MSBs.
  function automatic logic [7:0] hx(input logic [3:0] v);
    return (v < 4'd10) ? 8'(48 + v) : 8'(55 + v);
  endfunction

  function automatic logic [63:0] line_of(input logic [3:0] pc, input logic [7:0] inst,
                                          input logic [3:0] io);
    return {hx(pc), 8'h3A, hx(inst[7:4]), hx(inst[3:0]), 8'h20, hx(io), 8'h0D, 8'h0A};
  endfunction

  // UART receiver: samples every cycle on the falling clk edge.
  logic [7:0] rx_q[$];
  int   rx_cnt;
  logic slot_v [0:10];
  bit   rx_glitch;

  initial begin
    rx_cnt = -1;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        rx_cnt = -1;
      end else if (rx_cnt < 0) begin
        if (trc.tx === 1'b0) begin
          rx_cnt    = 1;
          slot_v[0] = 1'b0;
          rx_glitch = 1'b0;
        end
      end else begin
        int slot;
        slot = rx_cnt / CPB;
        if (rx_cnt % CPB == 0) slot_v[slot] = trc.tx;
        else if (trc.tx !== slot_v[slot]) rx_glitch = 1'b1;
        rx_cnt++;
        if (rx_cnt == FRAME_BITS * CPB) begin
          logic [7:0] b;
          for (int i = 0; i < 8; i++) b[i] = slot_v[1 + i];
          rx_q.push_back(b);
          chk("bit_hold", {63'd0, rx_glitch}, 64'd0);
          chk("stop_bit", {63'd0, slot_v[FRAME_BITS - 1]}, 64'd1);
`ifdef TRACE_UART_PARITY_EN
          chk("parity_bit", {63'd0, slot_v[9]}, {63'd0, ^b});
`endif
          rx_cnt = -1;
        end
      end
    end
  end

  // Busy-length monitor: length of the most recent completed busy pulse.
  int blen, last_blen;
  initial begin
    blen = 0;
    last_blen = 0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) blen = 0;
      else if (trc.busy === 1'b1) blen++;
      else if (blen > 0) begin
        last_blen = blen;
        blen = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic logic [63:0] q_line(input int base);
    logic [63:0] r = 64'd0;
    for (int i = 0; i < 8; i++)
      r = {r[55:0], (base + i < rx_q.size()) ? rx_q[base + i] : 8'h00};
    return r;
  endfunction

  // One clk_cpu pulse. Rise at r; event cycle holds r+2; busy visible at r+3.
  task automatic pulse_cpu(input logic [3:0] pc, input logic [7:0] inst, input logic [3:0] io,
                           input bit chk_lat, input bit clr_evt);
    trc.pc = pc; trc.inst = inst; trc.io_out = io;
    trc.clk_cpu = 1'b1;
    tick(2);
    if (chk_lat) chk("latency_early", {63'd0, trc.busy}, 64'd0);
    trc.drop_clr = clr_evt;
    tick(1);
    trc.drop_clr = 1'b0;
    if (chk_lat) chk("latency_start", {62'd0, trc.busy, trc.tx}, 64'b10);
    tick(1);
    trc.clk_cpu = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (trc.busy !== 1'b0 && n < 4 * LINE_CYC) begin
      tick(1);
      n++;
    end
    chk("idle_timeout", {63'd0, trc.busy}, 64'd0);
    tick(2);
  endtask

  task automatic run_line(input string name, input logic [3:0] pc, input logic [7:0] inst,
                          input logic [3:0] io, input logic [63:0] exp);
    rx_q.delete();
    pulse_cpu(pc, inst, io, 1'b1, 1'b0);
    wait_idle();
    chk({name, "_count"}, 64'(rx_q.size()), 64'd8);
    chk({name, "_line"}, q_line(0), exp);
    chk({name, "_busylen"}, 64'(last_blen), 64'(LINE_CYC));
    chk({name, "_nodrop"}, {63'd0, trc.drop}, 64'd0);
  endtask

  task automatic clear_drop();
    trc.drop_clr = 1'b1;
    tick(1);
    trc.drop_clr = 1'b0;
    chk("drop_clr", {63'd0, trc.drop}, 64'd0);
  endtask

  typedef struct {
    logic [3:0]  pc;
    logic [7:0]  inst;
    logic [3:0]  io;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{4'h3, 8'hB7, 4'hA, 64'h333A4237_20410D0A};
    vecs[1] = '{4'h0, 8'h00, 4'h0, 64'h303A3030_20300D0A};
    vecs[2] = '{4'hF, 8'h9F, 4'h5, 64'h463A3946_20350D0A};
    vecs[3] = '{4'hA, 8'h5C, 4'hF, 64'h413A3543_20460D0A};
    vecs[4] = '{4'h9, 8'hA0, 4'hE, 64'h393A4130_20450D0A};

    reset_n = 1'b0;
    trc.clk_cpu = 1'b0; trc.pc = 4'h0; trc.inst = 8'h00; trc.io_out = 4'h0;
    trc.drop_clr = 1'b0;

    // Reset held while clk_cpu toggles: outputs stay at reset values.
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (i % 3 == 0) trc.clk_cpu = ~trc.clk_cpu;
      chk("reset_hold", {61'd0, trc.tx, trc.busy, trc.drop}, 64'b100);
    end
    trc.clk_cpu = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(20);
    chk("post_reset_quiet", {62'd0, trc.tx, trc.busy}, 64'b10);
    chk("post_reset_nobytes", 64'(rx_q.size()), 64'd0);

    // Directed lines from the table.
    for (int i = 0; i < 5; i++) run_line($sformatf("vec%0d", i), vecs[i].pc, vecs[i].inst,
                                         vecs[i].io, vecs[i].exp);

    // Randomized lines against the model.
    for (int i = 0; i < 8; i++) begin
      logic [3:0] p; logic [7:0] n; logic [3:0] o;
      p = 4'($urandom_range(0, 15)); n = 8'($urandom_range(0, 255)); o = 4'($urandom_range(0, 15));
      tick($urandom_range(2, 10));
      run_line($sformatf("rnd%0d", i), p, n, o, line_of(p, n, o));
    end

    // Overrun: second rise 100 cycles after the first is dropped.
    rx_q.delete();
    pulse_cpu(4'h3, 8'hB7, 4'hA, 1'b1, 1'b0);
    tick(96);
    pulse_cpu(4'h5, 8'h12, 4'h1, 1'b0, 1'b0);
    chk("overrun_drop", {63'd0, trc.drop}, 64'd1);
    wait_idle();
    chk("overrun_count", 64'(rx_q.size()), 64'd8);
    chk("overrun_line", q_line(0), line_of(4'h3, 8'hB7, 4'hA));
    chk("overrun_busylen", 64'(last_blen), 64'(LINE_CYC));
    chk("overrun_sticky", {63'd0, trc.drop}, 64'd1);
    clear_drop();

    // Set/clear race: drop_clr in the dropping event cycle -> set wins.
    pulse_cpu(4'h1, 8'h23, 4'h4, 1'b1, 1'b0);
    tick(50);
    chk("race_pre", {63'd0, trc.drop}, 64'd0);
    pulse_cpu(4'h6, 8'h78, 4'h9, 1'b0, 1'b1);
    chk("race_set_wins", {63'd0, trc.drop}, 64'd1);
    wait_idle();
    clear_drop();

    // Step one cycle before the line ends: dropped.
    rx_q.delete();
    pulse_cpu(4'h7, 8'hC4, 4'h2, 1'b1, 1'b0);
    tick(LINE_CYC - 5);
    pulse_cpu(4'h8, 8'hD5, 4'h3, 1'b0, 1'b0);
    chk("edge_early_drop", {63'd0, trc.drop}, 64'd1);
    wait_idle();
    chk("edge_early_count", 64'(rx_q.size()), 64'd8);
    clear_drop();

    // Step in the very cycle busy falls: accepted, line follows seamlessly.
    rx_q.delete();
    pulse_cpu(4'hB, 8'hE1, 4'hC, 1'b1, 1'b0);
    tick(LINE_CYC - 4);
    pulse_cpu(4'h2, 8'h3F, 4'hD, 1'b0, 1'b0);
    chk("edge_accept_busy", {62'd0, trc.busy, trc.drop}, 64'b10);
    wait_idle();
    chk("edge_accept_count", 64'(rx_q.size()), 64'd16);
    chk("edge_accept_line1", q_line(0), line_of(4'hB, 8'hE1, 4'hC));
    chk("edge_accept_line2", q_line(8), line_of(4'h2, 8'h3F, 4'hD));
    chk("edge_accept_busylen", 64'(last_blen), 64'(2 * LINE_CYC));
    chk("edge_accept_nodrop", {63'd0, trc.drop}, 64'd0);

    // Mid-frame reset during character 3.
    rx_q.delete();
    pulse_cpu(4'h4, 8'h56, 4'h7, 1'b1, 1'b0);
    begin
      int n = 0;
      while (rx_q.size() < 3 && n < 2 * LINE_CYC) begin
        tick(1);
        n++;
      end
    end
    chk("midrst_reach", 64'(rx_q.size()), 64'd3);
    tick(3 * CPB);
    reset_n = 1'b0;
    #1;
    chk("midrst_async", {62'd0, trc.tx, trc.busy}, 64'b10);
    tick(3);
    chk("midrst_hold", {61'd0, trc.tx, trc.busy, trc.drop}, 64'b100);
    reset_n = 1'b1;
    tick(10);
    chk("midrst_quiet", {62'd0, trc.busy, 1'b0}, 64'd0);
    chk("midrst_partial", 64'(rx_q.size()), 64'd3);
    run_line("midrst_next", 4'hE, 8'h0B, 4'h6, line_of(4'hE, 8'h0B, 4'h6));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
